// File: rtl/switch_proc_pkg.sv
// Shared definitions for the switch-processing design: display-mode encoding,
// LED width and the mode-advance order.
package switch_proc_pkg;

    localparam int LED_W = 4;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_INC   = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_SCAN  = 2'd3
    } mode_e;

    function automatic mode_e next_mode(input mode_e m);
        case (m)
            MODE_PASS:  return MODE_INC;
            MODE_INC:   return MODE_BLINK;
            MODE_BLINK: return MODE_SCAN;
            default:    return MODE_PASS;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, counter-based debounce and a rising-edge pulse that
// fires on the same edge the debounced level flips from 0 to 1.
module btn_debounce #(
    parameter int DB_CYCLES = 1000000,
    parameter int DB_WIDTH  = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out,
    output logic rise
);

    localparam logic [DB_WIDTH-1:0] CNT_LAST = DB_WIDTH'(DB_CYCLES - 1);

    logic                sync1_q;
    logic                sync2_q;
    logic                db_q;
    logic                db_d;
    logic [DB_WIDTH-1:0] cnt_q;
    logic [DB_WIDTH-1:0] cnt_d;
    logic                flip;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= in;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    // The flip happens on the edge where the count would reach DB_CYCLES.
    always_comb begin
        flip  = (sync2_q != db_q) && (cnt_q == CNT_LAST);
        db_d  = db_q;
        cnt_d = '0;
        if (sync2_q != db_q) begin
            if (flip) begin
                db_d = sync2_q;
            end else begin
                cnt_d = cnt_q + DB_WIDTH'(1);
            end
        end
    end

    assign out  = db_q;
    assign rise = flip & sync2_q;

endmodule

// File: rtl/switch_mode_ctrl.sv
// Display-mode controller: synchronizes the switches, steps a 4-mode FSM on
// debounced button presses and drives the LEDs from a registered stage.
module switch_mode_ctrl
    import switch_proc_pkg::*;
#(
    parameter int HALF_PERIOD = 25000000,
    parameter int PH_WIDTH    = 28,
    parameter int DB_CYCLES   = 1000000,
    parameter int DB_WIDTH    = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LED_W-1:0] sw,
    input  logic             btn,
    output logic [LED_W-1:0] led,
    output logic [1:0]       mode,
    output logic             phase
);

    localparam logic [PH_WIDTH-1:0] PH_LAST = PH_WIDTH'(HALF_PERIOD - 1);

    logic [LED_W-1:0]    sw_s1_q;
    logic [LED_W-1:0]    sw_s_q;
    logic                btn_db;
    logic                adv;

    mode_e               mode_q;
    mode_e               mode_d;
    logic [PH_WIDTH-1:0] ph_cnt_q;
    logic [PH_WIDTH-1:0] ph_cnt_d;
    logic                phase_q;
    logic                phase_d;
    logic [1:0]          scan_idx_q;
    logic [1:0]          scan_idx_d;
    logic [LED_W-1:0]    led_q;
    logic [LED_W-1:0]    led_d;
    logic [LED_W-1:0]    sw_inc;
    logic                wrap;

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES),
        .DB_WIDTH  (DB_WIDTH)
    ) u_btn_debounce (
        .clk  (clk),
        .rst  (rst),
        .in   (btn),
        .out  (btn_db),
        .rise (adv)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_s1_q    <= '0;
            sw_s_q     <= '0;
            mode_q     <= MODE_PASS;
            ph_cnt_q   <= '0;
            phase_q    <= 1'b0;
            scan_idx_q <= '0;
            led_q      <= '0;
        end else begin
            sw_s1_q    <= sw;
            sw_s_q     <= sw_s1_q;
            mode_q     <= mode_d;
            ph_cnt_q   <= ph_cnt_d;
            phase_q    <= phase_d;
            scan_idx_q <= scan_idx_d;
            led_q      <= led_d;
        end
    end

    // A press restarts the phase in its lit half and overrides a same-cycle wrap.
    always_comb begin
        mode_d     = mode_q;
        ph_cnt_d   = ph_cnt_q + PH_WIDTH'(1);
        phase_d    = phase_q;
        scan_idx_d = scan_idx_q;
        wrap       = (ph_cnt_q == PH_LAST);
        sw_inc     = sw_s_q + LED_W'(1);
        led_d      = sw_s_q;

        if (adv) begin
            mode_d   = next_mode(mode_q);
            ph_cnt_d = '0;
            phase_d  = 1'b1;
            if (mode_q == MODE_BLINK) begin
                scan_idx_d = '0;
            end
        end else if (wrap) begin
            ph_cnt_d = '0;
            phase_d  = ~phase_q;
            if (mode_q == MODE_SCAN) begin
                scan_idx_d = scan_idx_q + 2'd1;
            end
        end

        case (mode_q)
            MODE_PASS:  led_d = sw_s_q;
            MODE_INC:   led_d = sw_inc;
            MODE_BLINK: led_d = phase_q ? sw_inc : '0;
            MODE_SCAN:  led_d = LED_W'(1) << scan_idx_q;
            default:    led_d = sw_s_q;
        endcase
    end

    assign led   = led_q;
    assign mode  = mode_q;
    assign phase = phase_q;

    logic unused_btn_db;
    assign unused_btn_db = btn_db;

endmodule

// File: tb/tb_switch_mode_ctrl.sv
// Directed bench for switch_mode_ctrl with HALF_PERIOD=4, DB_CYCLES=3.
// Expectations are queued against a cycle number; a negedge monitor checks them.
module tb_switch_mode_ctrl;

  localparam int HALF_PERIOD = 4;
  localparam int DB_CYCLES   = 3;

  localparam int K_LED   = 0;
  localparam int K_MODE  = 1;
  localparam int K_PHASE = 2;

  typedef struct {
    int         at;
    int         kind;
    logic [3:0] val;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [3:0] sw;
  logic       btn;
  logic [3:0] led;
  logic [1:0] mode;
  logic       phase;

  int   cyc;
  int   n_cmp;
  int   n_bad;
  exp_t exp_q[$];

  switch_mode_ctrl #(
    .HALF_PERIOD (HALF_PERIOD),
    .PH_WIDTH    (3),
    .DB_CYCLES   (DB_CYCLES),
    .DB_WIDTH    (4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .sw    (sw),
    .btn   (btn),
    .led   (led),
    .mode  (mode),
    .phase (phase)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc++;

  // scoreboard monitor
  always @(negedge clk) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].at == cyc) begin
        logic [3:0] act;
        string      nm;
        case (exp_q[i].kind)
          K_LED:   begin act = led;             nm = "led";   end
          K_MODE:  begin act = {2'b00, mode};   nm = "mode";  end
          default: begin act = {3'b000, phase}; nm = "phase"; end
        endcase
        n_cmp++;
        if (act !== exp_q[i].val) begin
          n_bad++;
          $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp_q[i].val);
        end
        exp_q.delete(i);
      end
    end
  end

  // driver helpers
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push_exp(input int dly, input int kind, input logic [3:0] v);
    exp_t e;
    e.at   = cyc + dly;
    e.kind = kind;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  // Accepted press: adv lands 5 edges after the drive point.
  task automatic press(input logic [3:0] prev_m, input logic [3:0] new_m);
    push_exp(4,  K_MODE,  prev_m);
    push_exp(5,  K_MODE,  new_m);
    push_exp(5,  K_PHASE, 4'h1);
    push_exp(14, K_MODE,  new_m);
    btn = 1'b1;
    tick(6);
    btn = 1'b0;
    tick(8);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b0;
    sw    = 4'hA;
    btn   = 1'b0;

    // reset and release
    tick(2);
    n_cmp++;
    if (led !== 4'h0) begin
      n_bad++;
      $display("FAIL led in reset: got %h expected 0", led);
    end
    n_cmp++;
    if (mode !== 2'd0) begin
      n_bad++;
      $display("FAIL mode in reset: got %h expected 0", mode);
    end
    n_cmp++;
    if (phase !== 1'b0) begin
      n_bad++;
      $display("FAIL phase in reset: got %b expected 0", phase);
    end
    push_exp(0, K_LED,   4'h0);
    push_exp(0, K_MODE,  4'h0);
    push_exp(0, K_PHASE, 4'h0);
    rst = 1'b1;
    push_exp(2, K_LED,   4'h0);
    push_exp(3, K_LED,   4'hA);
    push_exp(3, K_PHASE, 4'h0);
    push_exp(4, K_PHASE, 4'h1);
    tick(6);

    // reset mid-operation
    rst = 1'b0;
    push_exp(0, K_LED,   4'h0);
    push_exp(0, K_MODE,  4'h0);
    push_exp(0, K_PHASE, 4'h0);
    tick(1);
    rst = 1'b1;
    push_exp(2, K_LED,  4'h0);
    push_exp(3, K_LED,  4'hA);
    push_exp(3, K_MODE, 4'h0);
    tick(5);

    // glitch shorter than the debounce window
    for (int d = 2; d <= 8; d += 2) push_exp(d, K_MODE, 4'h0);
    btn = 1'b1;
    tick(2);
    btn = 1'b0;
    tick(8);

    // PASS -> INC, led becomes sw+1
    push_exp(6, K_LED, 4'hB);
    press(4'h0, 4'h1);

    // INC wrap and plain increment
    sw = 4'hF;
    push_exp(2, K_LED, 4'hB);
    push_exp(3, K_LED, 4'h0);
    tick(4);
    sw = 4'h7;
    push_exp(3, K_LED, 4'h8);
    tick(4);
    sw = 4'h3;
    tick(4);

    // INC -> BLINK
    for (int d = 6; d <= 9; d++)   push_exp(d, K_LED, 4'h4);
    for (int d = 10; d <= 13; d++) push_exp(d, K_LED, 4'h0);
    push_exp(14, K_LED, 4'h4);
    for (int d = 6; d <= 8; d++)   push_exp(d, K_PHASE, 4'h1);
    push_exp(9, K_PHASE, 4'h0);
    press(4'h1, 4'h2);
    tick(6);

    // BLINK -> SCAN, adv aligned with a wrap that would clear phase
    for (int d = 6; d <= 21; d++) push_exp(d, K_LED, 4'(1 << ((d - 6) / 4)));
    push_exp(22, K_LED, 4'h1);
    press(4'h2, 4'h3);
    tick(8);

    // SCAN -> PASS
    push_exp(6, K_LED, 4'h3);
    push_exp(10, K_LED, 4'h3);
    press(4'h3, 4'h0);
    tick(3);

    n_cmp++;
    if (mode !== 2'd0) begin
      n_bad++;
      $display("FAIL final mode: got %h expected 0", mode);
    end
    n_cmp++;
    if (led !== sw) begin
      n_bad++;
      $display("FAIL final led: got %h expected %h", led, sw);
    end

    while (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unchecked kind %0d @cyc %0d: never compared, expected %h",
               exp_q[0].kind, exp_q[0].at, exp_q[0].val);
      void'(exp_q.pop_front());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
